// File: rtl/regfile_pkg.sv
// Shared definitions for the register save/restore sequencer: register indices,
// datapath widths and the sequencer state encoding.
package regfile_pkg;
    localparam int DATA_W = 10;
    localparam int ADDR_W = 10;

    localparam logic [2:0] S0     = 3'd0;
    localparam logic [2:0] S1     = 3'd1;
    localparam logic [2:0] S2     = 3'd2;
    localparam logic [2:0] S3     = 3'd3;
    localparam logic [2:0] RA     = 3'd6;
    localparam logic [2:0] SP     = 3'd7;
    localparam logic [2:0] SP_IDX = SP;

    localparam logic [7:0] DEFAULT_MASK =
        (8'd1 << S0) | (8'd1 << S1) | (8'd1 << S2) | (8'd1 << S3) | (8'd1 << RA);

    typedef enum logic [2:0] {
        IDLE, LD_SP, S_RD, S_WR, R_RD, R_WR, SP_WB, DONE
    } state_t;
endpackage

// File: rtl/reg_mask_scan.sv
// Combinational next-set-bit finder over registers 0..6. A current index of 7
// means "not started yet", so the first search covers the whole range.
module reg_mask_scan (
    input  logic [6:0] mask,
    input  logic [2:0] cur,
    input  logic       up,
    output logic [2:0] next_idx,
    output logic       none
);
    always_comb begin
        next_idx = 3'd0;
        none     = 1'b1;
        if (up) begin
            // Walk downward so the last hit is the lowest index above cur.
            for (int i = 6; i >= 0; i--) begin
                if (mask[i] && (cur == 3'd7 || 3'(i) > cur)) begin
                    next_idx = 3'(i);
                    none     = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i <= 6; i++) begin
                if (mask[i] && 3'(i) < cur) begin
                    next_idx = 3'(i);
                    none     = 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/regfile_save_restore.sv
// Saves/restores masked general registers to/from the memory stack and writes
// back the stack pointer. All outputs are registered and set on state entry.
module regfile_save_restore #(
    parameter logic [7:0] SAVE_MASK = regfile_pkg::DEFAULT_MASK,
    parameter int         DATA_W    = regfile_pkg::DATA_W,
    parameter int         ADDR_W    = regfile_pkg::ADDR_W,
    parameter logic [2:0] SP_IDX    = regfile_pkg::SP_IDX
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              save_req,
    input  logic              restore_req,
    output logic              busy,
    output logic              done,
    output logic [2:0]        rf_read_reg,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic [2:0]        rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    import regfile_pkg::*;

    state_t            state;
    logic              save_mode;
    logic [2:0]        idx;
    logic [ADDR_W-1:0] sp_work;
    logic [DATA_W-1:0] data_lat;
    logic [2:0]        scan_idx;
    logic              scan_none;

    reg_mask_scan u_scan (
        .mask     (SAVE_MASK[6:0]),
        .cur      (idx),
        .up       (save_mode),
        .next_idx (scan_idx),
        .none     (scan_none)
    );

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            save_mode     <= 1'b0;
            idx           <= 3'd0;
            sp_work       <= '0;
            data_lat      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rf_read_reg   <= 3'd0;
            rf_write_reg  <= 3'd0;
            rf_write_data <= '0;
            rf_write_en   <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            mem_re        <= 1'b0;
        end else begin
            busy          <= 1'b1;
            done          <= 1'b0;
            rf_read_reg   <= 3'd0;
            rf_write_reg  <= 3'd0;
            rf_write_data <= '0;
            rf_write_en   <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            mem_re        <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= save_req | restore_req;
                    if (save_req | restore_req) begin
                        state       <= LD_SP;
                        save_mode   <= save_req;
                        idx         <= 3'd7;
                        rf_read_reg <= SP_IDX;
                    end
                end
                LD_SP: begin
                    sp_work <= ADDR_W'(rf_read_data);
                    if (scan_none) begin
                        state         <= SP_WB;
                        rf_write_en   <= 1'b1;
                        rf_write_reg  <= SP_IDX;
                        rf_write_data <= rf_read_data;
                    end else begin
                        idx <= scan_idx;
                        if (save_mode) begin
                            state       <= S_RD;
                            rf_read_reg <= scan_idx;
                        end else begin
                            state    <= R_RD;
                            mem_re   <= 1'b1;
                            mem_addr <= ADDR_W'(rf_read_data);
                        end
                    end
                end
                S_RD: begin
                    data_lat  <= rf_read_data;
                    sp_work   <= sp_work - 1'b1;
                    state     <= S_WR;
                    mem_we    <= 1'b1;
                    mem_addr  <= sp_work - 1'b1;
                    mem_wdata <= rf_read_data;
                end
                S_WR: begin
                    if (!mem_ready) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= sp_work;
                        mem_wdata <= data_lat;
                    end else if (scan_none) begin
                        state         <= SP_WB;
                        rf_write_en   <= 1'b1;
                        rf_write_reg  <= SP_IDX;
                        rf_write_data <= DATA_W'(sp_work);
                    end else begin
                        idx         <= scan_idx;
                        state       <= S_RD;
                        rf_read_reg <= scan_idx;
                    end
                end
                R_RD: begin
                    if (!mem_ready) begin
                        mem_re   <= 1'b1;
                        mem_addr <= sp_work;
                    end else begin
                        data_lat      <= mem_rdata;
                        sp_work       <= sp_work + 1'b1;
                        state         <= R_WR;
                        rf_write_en   <= 1'b1;
                        rf_write_reg  <= idx;
                        rf_write_data <= mem_rdata;
                    end
                end
                R_WR: begin
                    if (scan_none) begin
                        state         <= SP_WB;
                        rf_write_en   <= 1'b1;
                        rf_write_reg  <= SP_IDX;
                        rf_write_data <= DATA_W'(sp_work);
                    end else begin
                        idx      <= scan_idx;
                        state    <= R_RD;
                        mem_re   <= 1'b1;
                        mem_addr <= sp_work;
                    end
                end
                SP_WB: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_save_restore.sv
// Randomized bench for regfile_save_restore: a register-file/memory environment
// plus an expected-transaction model derived from the stack save/restore rules.
module tb_regfile_save_restore;
    localparam logic [7:0] MASK = 8'b0100_1111;

    typedef struct packed {logic we; logic [9:0] addr; logic [9:0] data;} macc_t;
    typedef struct packed {logic [2:0] r; logic [9:0] d;} rfw_t;

    logic       clk_in, reset, save_req, restore_req, busy, done;
    logic [2:0] rf_read_reg, rf_write_reg;
    logic [9:0] rf_read_data, rf_write_data, mem_addr, mem_wdata, mem_rdata;
    logic       rf_write_en, mem_we, mem_re, mem_ready;

    logic [9:0] regs [8];
    logic [9:0] exp_regs [8];
    logic [9:0] pre_regs [8];
    logic [9:0] mem [1024];
    logic [9:0] exp_mem [1024];
    logic [9:0] pre_mem [1024];
    macc_t      mq[$];
    rfw_t       rq[$];
    int         checks = 0, errors = 0;
    int         exp_base = 0, last_lat = 0, wr_count = 0;
    int         ready_mode = 0, stall_left = 0;

    regfile_save_restore dut (
        .clk_in(clk_in), .reset(reset), .save_req(save_req), .restore_req(restore_req),
        .busy(busy), .done(done), .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
        .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data), .rf_write_en(rf_write_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    assign rf_read_data = regs[rf_read_reg];
    assign mem_rdata    = mem_ready ? mem[mem_addr] : 10'h2AA;

    always @(posedge clk_in) begin
        if (mem_we && mem_ready) mem[mem_addr] = mem_wdata;
        if (rf_write_en) regs[rf_write_reg] = rf_write_data;
    end

    always @(posedge clk_in) begin
        #1;
        case (ready_mode)
            0: mem_ready = 1'b1;
            1: mem_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (mem_we && wr_count == 1 && stall_left > 0) begin
                    mem_ready = 1'b0;
                    stall_left--;
                end else mem_ready = 1'b1;
            end
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs();
        return {24'd0, done, rf_write_en, mem_we, mem_re, rf_read_reg, rf_write_reg,
                rf_write_data, mem_addr, mem_wdata};
    endfunction

    task automatic set_reg(input int i, input logic [9:0] v);
        regs[i] = v;
        exp_regs[i] = v;
    endtask

    // Expected memory/register traffic and final state of one sequence.
    task automatic model_start(input bit save);
        logic [9:0] sp, a, d;
        int n;
        pre_regs = exp_regs;
        pre_mem  = exp_mem;
        mq.delete();
        rq.delete();
        sp = exp_regs[7];
        n  = 0;
        if (save) begin
            for (int i = 0; i < 7; i++) if (MASK[i]) begin
                a = sp - 10'(n + 1);
                exp_mem[a] = exp_regs[i];
                mq.push_back({1'b1, a, exp_regs[i]});
                n++;
            end
            sp = sp - 10'(n);
        end else begin
            for (int i = 6; i >= 0; i--) if (MASK[i]) begin
                a = sp + 10'(n);
                d = exp_mem[a];
                exp_regs[i] = d;
                mq.push_back({1'b0, a, 10'd0});
                rq.push_back({3'(i), d});
                n++;
            end
            sp = sp + 10'(n);
        end
        rq.push_back({3'd7, sp});
        exp_regs[7] = sp;
        exp_base = 2 * n + 3;
    endtask

    always @(negedge clk_in) begin : cmp
        int         cyc, stalls;
        logic       prev_stall, prev_done;
        logic [21:0] prev_req;
        macc_t      e;
        rfw_t       w;
        if (reset) begin
            chk("reset_outputs", {outs(), busy}, 65'd0);
            cyc = 0; stalls = 0; prev_stall = 0; prev_done = 0; prev_req = '0;
        end else begin
            if (!busy) chk("idle_outputs", outs(), 64'd0);
            else cyc++;
            if (prev_done) chk("busy_fall", busy, 0);
            if (prev_stall) chk("stall_hold", {mem_we, mem_re, mem_addr, mem_wdata}, prev_req);
            if ((mem_we || mem_re) && !mem_ready) stalls++;
            if ((mem_we || mem_re) && mem_ready) begin
                if (mq.size() == 0) chk("mem_unexpected", {mem_we, mem_re, mem_addr}, 0);
                else begin
                    e = mq.pop_front();
                    chk("mem_access", {mem_we, mem_re, mem_addr, mem_we ? mem_wdata : 10'd0},
                        {e.we, ~e.we, e.addr, e.data});
                end
                if (mem_we) wr_count++;
            end
            if (rf_write_en) begin
                if (rq.size() == 0) chk("rf_unexpected", {rf_write_reg, rf_write_data}, 0);
                else begin
                    w = rq.pop_front();
                    chk("rf_write", {rf_write_reg, rf_write_data}, w);
                end
            end
            if (done) begin
                last_lat = cyc;
                chk("latency", cyc, exp_base + stalls);
                chk("queues_drained", mq.size() + rq.size(), 0);
                cyc = 0;
                stalls = 0;
            end
            prev_stall = (mem_we || mem_re) && !mem_ready;
            prev_req   = {mem_we, mem_re, mem_addr, mem_wdata};
            prev_done  = done;
        end
    end

    task automatic final_state();
        int mr, mm;
        mr = 0; mm = 0;
        for (int i = 0; i < 8; i++) if (regs[i] !== exp_regs[i]) mr++;
        for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) mm++;
        chk("final_regs", mr, 0);
        chk("final_mem", mm, 0);
    endtask

    task automatic run_op(input bit s, input bit r, input bit poke);
        int c;
        @(posedge clk_in); #1;
        chk("idle_before_req", busy, 0);
        wr_count = 0;
        model_start(s);
        save_req = s;
        restore_req = r;
        @(posedge clk_in); #1;
        save_req = 0;
        restore_req = 0;
        chk("busy_rise", busy, 1);
        if (poke) begin
            @(posedge clk_in); #1; restore_req = 1;
            @(posedge clk_in); #1; restore_req = 0;
        end
        c = 0;
        while (!done && c < 400) begin @(negedge clk_in); c++; end
        chk("done_seen", done, 1);
        if (done) final_state();
        else begin mq.delete(); rq.delete(); end
        @(negedge clk_in);
    endtask

    task automatic load_test_regs();
        set_reg(0, 10'd1); set_reg(1, 10'd2); set_reg(2, 10'd3); set_reg(3, 10'd4);
        set_reg(6, 10'h155); set_reg(7, 10'h200);
    endtask

    initial begin : main
        int  c;
        logic sv;
        reset = 1; save_req = 0; restore_req = 0; mem_ready = 1;
        for (int i = 0; i < 1024; i++) begin mem[i] = 10'($urandom); exp_mem[i] = mem[i]; end
        for (int i = 0; i < 8; i++) set_reg(i, 10'd0);
        repeat (3) @(posedge clk_in); #1;
        reset = 0;
        @(negedge clk_in);
        chk("post_reset", {outs(), busy}, 65'd0);

        // Directed save
        load_test_regs();
        run_op(1, 0, 0);
        chk("save_mem_1ff", mem[10'h1FF], 10'd1);
        chk("save_mem_1fe", mem[10'h1FE], 10'd2);
        chk("save_mem_1fd", mem[10'h1FD], 10'd3);
        chk("save_mem_1fc", mem[10'h1FC], 10'd4);
        chk("save_mem_1fb", mem[10'h1FB], 10'h155);
        chk("save_sp", regs[7], 10'h1FB);
        chk("save_lat13", last_lat, 13);

        // Clobber and restore
        set_reg(0, 0); set_reg(1, 0); set_reg(2, 0); set_reg(3, 0); set_reg(6, 0);
        run_op(0, 1, 0);
        chk("restore_regs", {regs[0], regs[1], regs[2], regs[3], regs[6]},
            {10'd1, 10'd2, 10'd3, 10'd4, 10'h155});
        chk("restore_sp", regs[7], 10'h200);
        chk("restore_lat13", last_lat, 13);

        // Wrap below address zero
        set_reg(7, 10'h002);
        run_op(1, 0, 0);
        chk("wrap_addrs", {mem[10'h001], mem[10'h000], mem[10'h3FF], mem[10'h3FE], mem[10'h3FD]},
            {10'd1, 10'd2, 10'd3, 10'd4, 10'h155});
        chk("wrap_sp", regs[7], 10'h3FD);

        // Three-cycle stall on the second write
        load_test_regs();
        ready_mode = 2; stall_left = 3;
        run_op(1, 0, 0);
        chk("stall_lat16", last_lat, 16);
        ready_mode = 0;

        // Both requests together, then a restore pulse while busy
        load_test_regs();
        run_op(1, 1, 1);
        chk("both_save_sp", regs[7], 10'h1FB);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            chk("no_second_seq", busy, 0);
        end

        // Reset after two memory writes
        load_test_regs();
        @(posedge clk_in); #1;
        wr_count = 0;
        model_start(1);
        save_req = 1;
        @(posedge clk_in); #1;
        save_req = 0;
        c = 0;
        while (wr_count < 2 && c < 100) begin @(negedge clk_in); c++; end
        chk("two_writes_seen", wr_count, 2);
        @(posedge clk_in); #1;
        reset = 1; #1;
        chk("reset_mid_outputs", {outs(), busy}, 65'd0);
        foreach (mq[k]) if (mq[k].we) exp_mem[mq[k].addr] = pre_mem[mq[k].addr];
        exp_regs = pre_regs;
        mq.delete(); rq.delete();
        chk("reset_sp_kept", regs[7], 10'h200);
        chk("reset_writes_kept", {mem[10'h1FF], mem[10'h1FE]}, {10'd1, 10'd2});
        chk("reset_no_third", mem[10'h1FD], pre_mem[10'h1FD]);
        final_state();
        repeat (2) @(posedge clk_in); #1;
        reset = 0;
        run_op(1, 0, 0);
        chk("resave_sp", regs[7], 10'h1FB);

        // Randomized traffic with random memory stalls
        ready_mode = 1;
        for (int it = 0; it < 24; it++) begin
            sv = 1'($urandom_range(0, 1));
            if (sv && $urandom_range(0, 1) == 1)
                for (int i = 0; i < 8; i++) set_reg(i, 10'($urandom));
            run_op(sv, ~sv, 0);
        end
        ready_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
